// File: rtl/uart_fifo_bridge.sv
// Memory-mapped UART bridge: CPU bytes queue in a TX FIFO drained by a small FSM; uart RX bytes queue in an RX FIFO.
// Optional CTRL register and registered interrupt output are enabled by UART_BRIDGE_IRQ_EN.
module uart_fifo_bridge #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF40,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_i,
    input  logic [7:0]  di_i,
    input  logic        we_i,
    output logic [7:0]  do_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_wr_o,
    input  logic        tx_done_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_done_i
`ifdef UART_BRIDGE_IRQ_EN
    ,
    output logic        irq_o
`endif
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

    tx_state_e     state_q;
    logic [7:0]    tx_data_q;
    logic          tx_wr_q;
    logic          tx_busy;

    // Register window decode
    logic [15:0]   offs;
    logic          in_win;
    logic          wr_data, wr_stat, wr_pop;

    assign offs    = addr_i - BASE_ADDR;
    assign in_win  = offs < 16'd4;
    assign wr_data = we_i && in_win && (offs[1:0] == 2'd0);
    assign wr_stat = we_i && in_win && (offs[1:0] == 2'd1);
    assign wr_pop  = we_i && in_win && (offs[1:0] == 2'd2);

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == CW'(0));
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == CW'(0));

    // Full/empty come from the pre-edge count, so a push into a full FIFO is lost even with a concurrent pop
    assign tx_push  = wr_data && !tx_full;
    assign tx_pop   = (state_q == TX_IDLE) && !tx_empty;
    assign rx_push  = rx_done_i && !rx_full;
    assign rx_pop   = wr_pop && !rx_empty;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
        if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        // Sticky flags: a set in the same cycle as a clear wins
        tx_ovf_d = (wr_data && tx_full) || (tx_ovf_q && !(wr_stat && di_i[4]));
        rx_ovr_d = (rx_done_i && rx_full) || (rx_ovr_q && !(wr_stat && di_i[3]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
        end
    end

    // FIFO storage needs no reset; stale entries are never visible through the pointers
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= di_i;
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data_i;
    end

    // TX drain: tx_wr is registered off TX_START, so it lands two edges after the write into an idle bridge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
        end else begin
            tx_wr_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_data_q <= tx_mem[tx_rptr_q];
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    tx_wr_q <= 1'b1;
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done_i) state_q <= TX_IDLE;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_busy   = (state_q != TX_IDLE);
    assign tx_data_o = tx_data_q;
    assign tx_wr_o   = tx_wr_q;

    logic [7:0] ctrl_rd;

`ifdef UART_BRIDGE_IRQ_EN
    logic       wr_ctrl;
    logic [1:0] ctrl_q;
    logic       irq_q;

    assign wr_ctrl = we_i && in_win && (offs[1:0] == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= di_i[1:0];
            irq_q <= (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty && !tx_busy);
        end
    end

    assign ctrl_rd = {6'b000000, ctrl_q};
    assign irq_o   = irq_q;
`else
    assign ctrl_rd = 8'h00;
`endif

    // Read mux, combinational from addr
    always_comb begin
        do_o = 8'h00;
        if (in_win) begin
            case (offs[1:0])
                2'd0:    do_o = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
                2'd1:    do_o = {3'b000, tx_ovf_q, rx_ovr_q, tx_busy, tx_full, !rx_empty};
                2'd2:    do_o = 8'h00;
                default: do_o = ctrl_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed scenarios plus random traffic against a queue-based model.
// Define UART_BRIDGE_IRQ_EN for both bench and RTL to cover the interrupt build.
module tb_uart_fifo_bridge;
    localparam logic [15:0] BASE   = 16'hFF40;
    localparam logic [15:0] A_DATA = BASE;
    localparam logic [15:0] A_STAT = BASE + 16'd1;
    localparam logic [15:0] A_POP  = BASE + 16'd2;
    localparam logic [15:0] A_CTRL = BASE + 16'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_i = 16'h0000;
    logic [7:0]  di_i = 8'h00;
    logic        we_i = 1'b0;
    logic [7:0]  do_o;
    logic [7:0]  tx_data_o;
    logic        tx_wr_o;
    logic        tx_done_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_done_i = 1'b0;
`ifdef UART_BRIDGE_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk = ~clk;

    uart_fifo_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr_i),
        .di_i      (di_i),
        .we_i      (we_i),
        .do_o      (do_o),
        .tx_data_o (tx_data_o),
        .tx_wr_o   (tx_wr_o),
        .tx_done_i (tx_done_i),
        .rx_data_i (rx_data_i),
        .rx_done_i (rx_done_i)
`ifdef UART_BRIDGE_IRQ_EN
        ,
        .irq_o     (irq_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, transmitter as "byte in flight" with edge stamps
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] sent[$];
    logic       m_busy, m_ovf, m_ovr, m_irq;
    logic [1:0] m_ctrl;
    logic [7:0] m_txdata;
    int         n = 0;
    int         wr_edge, wait_from;

    function automatic void model_reset();
        txq.delete();
        rxq.delete();
        m_busy    = 1'b0;
        m_ovf     = 1'b0;
        m_ovr     = 1'b0;
        m_irq     = 1'b0;
        m_ctrl    = 2'b00;
        m_txdata  = 8'h00;
        wr_edge   = -10;
        wait_from = 0;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        logic [15:0] off;
        logic [7:0]  r;
        off = a - BASE;
        r = 8'h00;
        if (off < 16'd4) begin
            case (off[1:0])
                2'd0: r = (rxq.size() > 0) ? rxq[0] : 8'h00;
                2'd1: r = {3'b000, m_ovf, m_ovr, m_busy, (txq.size() == 8), (rxq.size() > 0)};
                2'd3: r = {6'b000000, m_ctrl};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    function automatic void model_step(input logic we, input logic [15:0] a, input logic [7:0] d,
                                       input logic td, input logic rd, input logic [7:0] rdat);
        logic [15:0] off;
        logic inw, w0, w1, w2, w3, txfull, txempty, rxfull, rxempty, busy_pre;
        n++;
        off  = a - BASE;
        inw  = (off < 16'd4);
        w0   = we && inw && (off[1:0] == 2'd0);
        w1   = we && inw && (off[1:0] == 2'd1);
        w2   = we && inw && (off[1:0] == 2'd2);
        w3   = we && inw && (off[1:0] == 2'd3);
        txfull   = (txq.size() == 8);
        txempty  = (txq.size() == 0);
        rxfull   = (rxq.size() == 8);
        rxempty  = (rxq.size() == 0);
        busy_pre = m_busy;
        m_irq = (m_ctrl[0] && !rxempty) || (m_ctrl[1] && txempty && !busy_pre);
        if (!busy_pre && !txempty) begin
            m_txdata  = txq.pop_front();
            m_busy    = 1'b1;
            wr_edge   = n + 1;
            wait_from = n + 2;
        end else if (busy_pre && td && n >= wait_from) begin
            m_busy = 1'b0;
        end
        if (w0 && !txfull) txq.push_back(d);
        m_ovf = (w0 && txfull) || (m_ovf && !(w1 && d[4]));
        m_ovr = (rd && rxfull) || (m_ovr && !(w1 && d[3]));
        if (w2 && !rxempty) void'(rxq.pop_front());
        if (rd && !rxfull) rxq.push_back(rdat);
`ifdef UART_BRIDGE_IRQ_EN
        if (w3) m_ctrl = d[1:0];
`else
        if (w3) m_ctrl = m_ctrl;
`endif
    endfunction

    // One clock cycle: drive, check the read mux, take the edge, check registered outputs
    task automatic cyc(input logic we, input logic [15:0] a, input logic [7:0] d,
                       input logic td, input logic rd, input logic [7:0] rdat);
        logic exp_wr;
        we_i = we; addr_i = a; di_i = d; tx_done_i = td; rx_done_i = rd; rx_data_i = rdat;
        #1;
        check_eq($sformatf("do@%h", a), do_o, exp_rd(a));
        @(posedge clk);
        model_step(we, a, d, td, rd, rdat);
        #1;
        exp_wr = m_busy && (n == wr_edge);
        check_eq("tx_wr", {7'b0, tx_wr_o}, {7'b0, exp_wr});
        check_eq("tx_data", tx_data_o, m_txdata);
`ifdef UART_BRIDGE_IRQ_EN
        check_eq("irq", {7'b0, irq_o}, {7'b0, m_irq});
`endif
        if (tx_wr_o) sent.push_back(tx_data_o);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, a, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        cyc(1'b0, A_STAT, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rxb(input logic [7:0] b);
        cyc(1'b0, A_STAT, 8'h00, 1'b0, 1'b1, b);
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] v);
        we_i = 1'b0;
        addr_i = a;
        #1;
        v = do_o;
    endtask

    initial begin
        logic [7:0] v;
        model_reset();

        // Reset state
        #2;
        peek(A_STAT, v);  check_eq("rst_status", v, 8'h00);
        peek(A_DATA, v);  check_eq("rst_data", v, 8'h00);
        check_eq("rst_tx_wr", {7'b0, tx_wr_o}, 8'h00);
        check_eq("rst_tx_data", tx_data_o, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: tx_wr two edges after the write
        wr(A_DATA, 8'h41);
        check_eq("t1_wr_e0", {7'b0, tx_wr_o}, 8'h00);
        idle();
        check_eq("t1_wr_e1", {7'b0, tx_wr_o}, 8'h00);
        idle();
        check_eq("t1_wr_e2", {7'b0, tx_wr_o}, 8'h01);
        check_eq("t1_data", tx_data_o, 8'h41);
        idle();
        check_eq("t1_wr_e3", {7'b0, tx_wr_o}, 8'h00);
        peek(A_STAT, v);  check_eq("t1_busy", v, 8'h04);
        cyc(1'b0, A_STAT, 8'h00, 1'b1, 1'b0, 8'h00);
        peek(A_STAT, v);  check_eq("t1_done", v, 8'h00);

        // RX basic peek/pop
        rxb(8'h55);
        rxb(8'hAA);
        peek(A_STAT, v);  check_eq("t3_status", v, 8'h01);
        peek(A_DATA, v);  check_eq("t3_head0", v, 8'h55);
        wr(A_POP, 8'h00);
        peek(A_DATA, v);  check_eq("t3_head1", v, 8'hAA);
        wr(A_POP, 8'h00);
        peek(A_STAT, v);  check_eq("t3_avail", {7'b0, v[0]}, 8'h00);

        // RX overrun
        for (int i = 0; i < 9; i++) rxb(8'h10 + 8'(i));
        peek(A_STAT, v);  check_eq("t4_ovr", {7'b0, v[3]}, 8'h01);
        peek(A_DATA, v);  check_eq("t4_head", v, 8'h10);
        wr(A_STAT, 8'h08);
        peek(A_STAT, v);  check_eq("t4_ovr_clr", {7'b0, v[3]}, 8'h00);

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 5; i++) wr(A_POP, 8'h00);
        cyc(1'b1, A_POP, 8'h00, 1'b0, 1'b1, 8'h99);
        peek(A_DATA, v);  check_eq("t5_h0", v, 8'h16);
        wr(A_POP, 8'h00);
        peek(A_DATA, v);  check_eq("t5_h1", v, 8'h17);
        wr(A_POP, 8'h00);
        peek(A_DATA, v);  check_eq("t5_h2", v, 8'h99);
        wr(A_POP, 8'h00);
        peek(A_STAT, v);  check_eq("t5_empty", v, 8'h00);

        // TX fill to capacity, overflow, drain in order
        sent.delete();
        for (int i = 0; i < 9; i++) wr(A_DATA, 8'(i));
        peek(A_STAT, v);  check_eq("t2_full", v, 8'h06);
        wr(A_DATA, 8'h09);
        peek(A_STAT, v);  check_eq("t2_ovf", v, 8'h16);
        repeat (40) cyc(1'b0, A_STAT, 8'h00, 1'b1, 1'b0, 8'h00);
        check_eq("t2_count", 8'(sent.size()), 8'd9);
        for (int i = 0; i < sent.size(); i++) check_eq($sformatf("t2_order%0d", i), sent[i], 8'(i));
        wr(A_STAT, 8'h10);
        peek(A_STAT, v);  check_eq("t2_ovf_clr", v, 8'h00);

        // Reset during TX_WAIT
        wr(A_DATA, 8'hC3);
        idle(); idle(); idle();
        peek(A_STAT, v);  check_eq("t5_wait_busy", v, 8'h04);
        rst_n = 1'b0;
        peek(A_STAT, v);  check_eq("t5_rst_status", v, 8'h00);
        check_eq("t5_rst_data", tx_data_o, 8'h00);
        model_reset();
        #1 rst_n = 1'b1;
        cyc(1'b0, A_STAT, 8'h00, 1'b1, 1'b0, 8'h00);
        peek(A_STAT, v);  check_eq("t5_late_done", v, 8'h00);

`ifdef UART_BRIDGE_IRQ_EN
        // RX interrupt
        wr(A_CTRL, 8'h01);
        peek(A_CTRL, v);  check_eq("t6_ctrl", v, 8'h01);
        rxb(8'h33);
        idle();
        check_eq("t6_irq_on", {7'b0, irq_o}, 8'h01);
        wr(A_POP, 8'h00);
        idle();
        check_eq("t6_irq_off", {7'b0, irq_o}, 8'h00);
        wr(A_CTRL, 8'h00);
`endif

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic        we, td, rd;
            logic [15:0] a;
            logic [7:0]  d, rdat;
            we   = ($urandom % 3) == 0;
            a    = BASE - 16'd1 + 16'($urandom_range(0, 5));
            d    = 8'($urandom);
            td   = ($urandom % 4) == 0;
            rd   = ($urandom % 3) == 0;
            rdat = 8'($urandom);
            cyc(we, a, d, td, rd, rdat);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
